// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with fixed-priority or round-robin selection,
// grant hold until done/drop, and an optional busy-cycle watchdog.
module bus_arbiter_n #(
    parameter int N_MST = 4,
    parameter int OWN_W = 2,
    parameter bit RR_EN = 1'b1,
    parameter int TMO   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_MST-1:0] req,
    input  logic [N_MST-1:0] done,
    output logic [N_MST-1:0] grnt,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic             tmo_err
);

    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam int NX = 2 ** OWN_W;
    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    logic             state_q, state_d;
    logic [N_MST-1:0] grnt_q, grnt_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    logic [NX-1:0]    req_x, done_x;
    logic [N_MST-1:0] arb_req;
    logic             rel, tmo_hit, do_arb;
    logic             win_vld;
    logic [OWN_W-1:0] win_idx;
    int               j;

    assign req_x  = NX'(req);
    assign done_x = NX'(done);

    assign rel = (state_q == S_BUSY) &&
                 (done_x[owner_q] || !req_x[owner_q]);

    // A plain release wins over a coincident timeout (no error pulse).
    assign tmo_hit = (TMO > 0) && (state_q == S_BUSY) && !rel &&
                     (cnt_q == CW'(TMO - 1));

    assign arb_req = req & ~(tmo_hit ? grnt_q : '0);
    assign do_arb  = (state_q == S_IDLE) || rel || tmo_hit;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = 0; k < N_MST; k++) begin
            j = RR_EN ? (int'(ptr_q) + k) % N_MST : k;
            if (!win_vld && arb_req[j]) begin
                win_vld = 1'b1;
                win_idx = OWN_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grnt_d  = grnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_hit;
        if (do_arb) begin
            cnt_d = '0;
            if (win_vld) begin
                state_d = S_BUSY;
                grnt_d  = N_MST'(1) << win_idx;
                owner_d = win_idx;
                if (RR_EN) begin
                    ptr_d = (win_idx == OWN_W'(N_MST - 1)) ?
                            '0 : win_idx + 1'b1;
                end
            end else begin
                state_d = S_IDLE;
                grnt_d  = '0;
            end
        end else if ((TMO > 0) && (cnt_q != CW'(TMO))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grnt_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grnt_q  <= grnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grnt    = grnt_q;
    assign owner   = owner_q;
    assign busy    = state_q;
    assign tmo_err = tmo_q;

endmodule
